fdivsqrt_otfc4_seq: RTL and testbench

- Radix-4 on-the-fly conversion (OTFC) and iteration-control stage for the digit-recurrence divide/sqrt datapath.
- Holds the C, U and UM registers consumed by the radix-4 F addend generator.
- Each busy cycle, it accepts the selected one-hot digit and updates U, UM and C.
- It counts iterations and signals completion with a start/done handshake.

---
 rtl/fdivsqrt_otfc4_seq_if.sv | 39 +++
 rtl/fdivsqrt_otfc4_seq.sv | 119 +++++++++++
 tb/tb_fdivsqrt_otfc4_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fdivsqrt_otfc4_seq_if.sv
// Handshake and datapath bundle for the radix-4 OTFC / iteration-control stage.
//   master: requester side (drives start, sqrt_mode, abort, udigit[, rem_zero])
//   slave : the fdivsqrt_otfc4_seq stage (drives busy, done, first_iter, C, U, UM)
// Optional: FDIVSQRT_EARLY_TERM_EN adds rem_zero (requester -> stage).
interface fdivsqrt_otfc4_seq_if #(
  parameter int unsigned DIVb = 64
);
  logic            start;
  logic            sqrt_mode;
  logic            abort;
  logic [3:0]      udigit;
  logic            busy;
  logic            done;
  logic            first_iter;
  logic [DIVb+3:0] C;
  logic [DIVb+3:0] U;
  logic [DIVb+3:0] UM;
`ifdef FDIVSQRT_EARLY_TERM_EN
  logic            rem_zero;

  modport master (
    output start, sqrt_mode, abort, udigit, rem_zero,
    input  busy, done, first_iter, C, U, UM
  );
  modport slave (
    input  start, sqrt_mode, abort, udigit, rem_zero,
    output busy, done, first_iter, C, U, UM
  );
`else
  modport master (
    output start, sqrt_mode, abort, udigit,
    input  busy, done, first_iter, C, U, UM
  );
  modport slave (
    input  start, sqrt_mode, abort, udigit,
    output busy, done, first_iter, C, U, UM
  );
`endif
endinterface

// File: rtl/fdivsqrt_otfc4_seq.sv
// Radix-4 on-the-fly conversion and iteration control for the digit-recurrence
// divide/sqrt datapath. Keeps the C (position mask), U (partial result) and UM
// (U minus one ulp) registers, all Q4.DIVb, and runs ITERS iterations per
// start/done handshake.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      fdivsqrt_otfc4_seq_if.slave: start, sqrt_mode, abort, udigit (one-hot
//            {2,1,-1,-2}, zero = digit 0) in; busy, done, first_iter, C, U, UM out
// Optional: FDIVSQRT_EARLY_TERM_EN adds bus.rem_zero; when high in a busy cycle
//           that cycle's digit is applied and the operation finishes.
module fdivsqrt_otfc4_seq #(
  parameter int unsigned DIVb  = 64,
  parameter int unsigned ITERS = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  fdivsqrt_otfc4_seq_if.slave  bus
);

  localparam int unsigned W    = DIVb + 4;
  localparam int unsigned CntW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ITERS - 1);
  // -0.25: ones from the sign down to bit DIVb-2
  localparam logic [W-1:0] C0  = {6'b111111, {(DIVb-2){1'b0}}};
  localparam logic [W-1:0] One = W'(1) << DIVb;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    c_q, c_d;
  logic [W-1:0]    u_q, u_d;
  logic [W-1:0]    um_q, um_d;
  logic [W-1:0]    k, k2;
  logic            early_term;

`ifdef FDIVSQRT_EARLY_TERM_EN
  assign early_term = bus.rem_zero;
`else
  assign early_term = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    u_d     = u_q;
    um_d    = um_q;
    // Lowest set bit of C is the weight of the current digit.
    k       = c_q & ~(c_q << 1);
    k2      = k << 1;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d = StBusy;
          cnt_d   = '0;
          c_d     = C0;
          u_d     = bus.sqrt_mode ? One : '0;
          um_d    = '0;
        end
      end
      StBusy: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          // Highest set udigit bit wins, matching the F generator.
          if (bus.udigit[3]) begin
            u_d  = u_q | k2;
            um_d = u_q | k;
          end else if (bus.udigit[2]) begin
            u_d  = u_q | k;
            um_d = u_q;
          end else if (bus.udigit[1]) begin
            u_d  = um_q | k2 | k;
            um_d = um_q | k2;
          end else if (bus.udigit[0]) begin
            u_d  = um_q | k2;
            um_d = um_q | k;
          end else begin
            um_d = um_q | k2 | k;
          end
          c_d   = {2'b11, c_q[W-1:2]};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt || early_term) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      c_q     <= '0;
      u_q     <= '0;
      um_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      u_q     <= u_d;
      um_q    <= um_d;
    end
  end

  assign bus.busy       = (state_q == StBusy);
  assign bus.done       = (state_q == StDone);
  assign bus.first_iter = (state_q == StBusy) && (cnt_q == '0);
  assign bus.C          = c_q;
  assign bus.U          = u_q;
  assign bus.UM         = um_q;

endmodule

// File: tb/tb_fdivsqrt_otfc4_seq.sv
// Self-checking bench for fdivsqrt_otfc4_seq (DIVb=8, ITERS=4). The reference
// keeps the result as a plain integer Q = U0 + sum(d_i * 4^-i) in units of
// 2^-DIVb; U, UM = Q - ulp and C = -4^-(j+1) are derived from it modulo 2^(DIVb+4).
module tb_fdivsqrt_otfc4_seq;

  localparam int unsigned DIVb  = 8;
  localparam int unsigned ITERS = 4;
  localparam int          W     = DIVb + 4;
  localparam int          Mask  = (1 << W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] dir_ud [ITERS];

  fdivsqrt_otfc4_seq_if #(.DIVb(DIVb)) bus ();

  fdivsqrt_otfc4_seq #(.DIVb(DIVb), .ITERS(ITERS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int digit_of(input logic [3:0] u);
    if (u[3]) return 2;
    if (u[2]) return 1;
    if (u[1]) return -1;
    if (u[0]) return -2;
    return 0;
  endfunction

  function automatic int ulp(input int j);
    return 1 << (DIVb - 2 * j);
  endfunction

  function automatic int c_exp(input int j);
    int e;
    e = DIVb - 2 * j - 2;
    return (e >= 0) ? ((-(1 << e)) & Mask) : Mask;
  endfunction

  // One full operation; directed digits come from dir_ud, else random.
  task automatic run_op(input bit sq, input bit directed, output int q);
    logic [3:0] ud;
    bus.start     = 1'b1;
    bus.sqrt_mode = sq;
    tick();
    bus.start     = 1'b0;
    bus.sqrt_mode = 1'($urandom);
    q = sq ? (1 << DIVb) : 0;
    check("load_busy", bus.busy, 1);
    check("load_first", bus.first_iter, 1);
    check("load_U", bus.U, q);
    check("load_UM", bus.UM, 0);
    check("load_C", bus.C, c_exp(0));
    for (int j = 1; j <= ITERS; j++) begin
      if (directed) ud = dir_ud[j-1];
      else if (j == 1 && !sq) ud = 4'($urandom_range(4, 15));  // divide starts positive
      else ud = 4'($urandom_range(0, 15));
      bus.udigit = ud;
      bus.start  = (j == 2);  // must be ignored while busy
      tick();
      bus.start  = 1'b0;
      q += digit_of(ud) * ulp(j);
      check("iter_U", bus.U, q & Mask);
      check("iter_UM", bus.UM, (q - ulp(j)) & Mask);
      check("iter_C", bus.C, c_exp(j));
      check("iter_busy", bus.busy, (j < ITERS));
      check("iter_done", bus.done, (j == ITERS));
      check("iter_first", bus.first_iter, 0);
    end
    bus.udigit = 4'($urandom);
    tick();
    check("idle_done", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_U_hold", bus.U, q & Mask);
  endtask

  initial begin
    int q;
    bus.start     = 1'b0;
    bus.sqrt_mode = 1'b0;
    bus.abort     = 1'b0;
    bus.udigit    = 4'd0;
`ifdef FDIVSQRT_EARLY_TERM_EN
    bus.rem_zero  = 1'b0;
`endif
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_first", bus.first_iter, 0);
    check("rst_U", bus.U, 0);
    check("rst_UM", bus.UM, 0);
    check("rst_C", bus.C, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Divide, digits 1,2,-1,0.
    dir_ud[0] = 4'b0100; dir_ud[1] = 4'b1000; dir_ud[2] = 4'b0010; dir_ud[3] = 4'b0000;
    run_op(1'b0, 1'b1, q);
    check("dir_div_U", bus.U, 12'h05C);
    check("dir_div_UM", bus.UM, 12'h05B);
    check("dir_div_C", bus.C, 12'hFFF);

    // Sqrt, digits -2,0,0,0.
    dir_ud[0] = 4'b0001; dir_ud[1] = 4'b0000; dir_ud[2] = 4'b0000; dir_ud[3] = 4'b0000;
    run_op(1'b1, 1'b1, q);
    check("dir_sqrt_U", bus.U, 12'h080);
    check("dir_sqrt_UM", bus.UM, 12'h07F);

    // Multi-hot 1010 behaves as digit 2.
    dir_ud[0] = 4'b1010;
    run_op(1'b0, 1'b1, q);
    check("multihot_U", bus.U, 12'h080);

    // Abort in the third busy cycle.
    bus.start = 1'b1; bus.sqrt_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.udigit = 4'b0100; tick();
    bus.udigit = 4'b1000; tick();
    q = 1 * ulp(1) + 2 * ulp(2);
    bus.udigit = 4'b1000; bus.abort = 1'b1; bus.start = 1'b1;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", bus.done, 0);
      check("abort_U", bus.U, q & Mask);
      check("abort_UM", bus.UM, (q - ulp(2)) & Mask);
      check("abort_C", bus.C, c_exp(2));
    end

    // Abort together with start in idle keeps the stage idle.
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_start_busy", bus.busy, 0);
    check("abort_start_C", bus.C, c_exp(2));

    // Reset in the middle of an operation.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.udigit = 4'b1000; tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_U", bus.U, 0);
    check("mid_rst_UM", bus.UM, 0);
    check("mid_rst_C", bus.C, 0);
    tick();
    check("mid_rst_done", bus.done, 0);
    reset_n = 1'b1;
    tick();
    run_op(1'b0, 1'b0, q);

`ifdef FDIVSQRT_EARLY_TERM_EN
    bus.start = 1'b1; bus.sqrt_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.udigit = 4'b0100; tick();
    bus.udigit = 4'b1000; bus.rem_zero = 1'b1; tick();
    bus.rem_zero = 1'b0; bus.udigit = 4'b0000;
    check("early_done", bus.done, 1);
    check("early_U", bus.U, 12'h060);
    check("early_UM", bus.UM, 12'h050);
    tick();
    check("early_idle", bus.done, 0);
    check("early_U_hold", bus.U, 12'h060);
`endif

    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom), 1'b0, q);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
